// File: rtl/pipe_rate_change_ctrl_pkg.sv
// Shared types and encoding helpers for the PIPE rate-change controller.
package pipe_rate_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ELEC_IDLE,
      ST_SET_RATE,
      ST_ACK,
      ST_DONE,
      ST_ERROR
   } state_e;

   localparam logic [1:0] WIDTH_CODE_8  = 2'd0;
   localparam logic [1:0] WIDTH_CODE_16 = 2'd1;
   localparam logic [1:0] WIDTH_CODE_32 = 2'd2;

   function automatic logic [3:0] gen_to_rate(input logic [2:0] gen);
      return {1'b0, gen - 3'd1};
   endfunction

   function automatic logic [4:0] gen_to_pclkrate(input logic [2:0] gen);
      return {2'b00, gen - 3'd1};
   endfunction

   function automatic logic [1:0] pipewidth_to_code(input int unsigned pipewidth);
      case (pipewidth)
         16:      return WIDTH_CODE_16;
         32:      return WIDTH_CODE_32;
         default: return WIDTH_CODE_8;
      endcase
   endfunction

endpackage

// File: rtl/pipe_rate_change_ctrl_if.sv
// LTSSM-side request/response bundle of the rate-change controller.
interface pipe_rate_change_ctrl_if #(
   parameter int unsigned LANESNUMBER = 16
);
   logic                   req_valid;
   logic [2:0]             req_gen;
   logic                   req_ready;
   logic [LANESNUMBER-1:0] active_lanes;
   logic                   done;
   logic                   error;
   logic [2:0]             cur_gen;
   logic                   force_elec_idle;

   modport master (
      output req_valid, req_gen, active_lanes,
      input  req_ready, done, error, cur_gen, force_elec_idle
   );

   modport slave (
      input  req_valid, req_gen, active_lanes,
      output req_ready, done, error, cur_gen, force_elec_idle
   );
endinterface

// File: rtl/pipe_rate_change_ctrl_collector.sv
// Sticky per-lane PhyStatus collector; all_done includes the current cycle's status.
module phystatus_collector #(
   parameter int unsigned LANESNUMBER = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [LANESNUMBER-1:0] phy_status,
   input  logic [LANESNUMBER-1:0] lane_mask,
   output logic                   all_done
);
   logic [LANESNUMBER-1:0] seen;
   logic [LANESNUMBER-1:0] hits;

   assign hits = phy_status & lane_mask;

   // Disabled means cleared, so a stale collection never leaks into the next change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         seen <= '0;
      else if (!enable)
         seen <= '0;
      else
         seen <= seen | hits;
   end

   assign all_done = enable && (&(seen | hits | ~lane_mask));
endmodule

// File: rtl/pipe_rate_change_ctrl.sv
// Sequences the MAC side of the PIPE Rate/PCLKRate handshake for a generation change.
module pipe_rate_change_ctrl
   import pipe_rate_pkg::*;
#(
   parameter int unsigned LANESNUMBER    = 16,
   parameter int unsigned GEN1_PIPEWIDTH = 8,
   parameter int unsigned GEN2_PIPEWIDTH = 8,
   parameter int unsigned GEN3_PIPEWIDTH = 8,
   parameter int unsigned GEN4_PIPEWIDTH = 8,
   parameter int unsigned GEN5_PIPEWIDTH = 8,
   parameter int unsigned MAX_GEN        = 1,
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                   CLK,
   input  logic                   lpreset,
   pipe_rate_change_ctrl_if.slave ltssm,
   output logic [3:0]             Rate,
   output logic [4:0]             PCLKRate,
   output logic [1:0]             width,
   input  logic                   PclkChangeOk,
   output logic                   PclkChangeAck,
   input  logic [LANESNUMBER-1:0] PhyStatus
);
   localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [WW-1:0] WD_LIMIT    = WW'(TIMEOUT_CYCLES);
   localparam logic [2:0]    MAX_GEN_C   = 3'(MAX_GEN);

   localparam logic [1:0] W1 = pipewidth_to_code(GEN1_PIPEWIDTH);
   localparam logic [1:0] W2 = pipewidth_to_code(GEN2_PIPEWIDTH);
   localparam logic [1:0] W3 = pipewidth_to_code(GEN3_PIPEWIDTH);
   localparam logic [1:0] W4 = pipewidth_to_code(GEN4_PIPEWIDTH);
   localparam logic [1:0] W5 = pipewidth_to_code(GEN5_PIPEWIDTH);

   function automatic logic [1:0] gen_to_width(input logic [2:0] gen);
      case (gen)
         3'd2:    return W2;
         3'd3:    return W3;
         3'd4:    return W4;
         3'd5:    return W5;
         default: return W1;
      endcase
   endfunction

   state_e                 state;
   logic [2:0]             target_gen;
   logic [LANESNUMBER-1:0] lane_mask;
   logic [SW-1:0]          settle_cnt;
   logic [WW-1:0]          wd_cnt;
   logic                   all_done;

   logic                   req_ready_q;
   logic                   done_q;
   logic                   error_q;
   logic [2:0]             cur_gen_q;
   logic                   fei_q;

   assign ltssm.req_ready       = req_ready_q;
   assign ltssm.done            = done_q;
   assign ltssm.error           = error_q;
   assign ltssm.cur_gen         = cur_gen_q;
   assign ltssm.force_elec_idle = fei_q;

   phystatus_collector #(.LANESNUMBER(LANESNUMBER)) u_collector (
      .clk        (CLK),
      .rst_n      (lpreset),
      .enable     (state == ST_ACK),
      .phy_status (PhyStatus),
      .lane_mask  (lane_mask),
      .all_done   (all_done)
   );

   always_ff @(posedge CLK or negedge lpreset) begin
      if (!lpreset) begin
         state         <= ST_IDLE;
         target_gen    <= 3'd1;
         lane_mask     <= '0;
         settle_cnt    <= '0;
         wd_cnt        <= '0;
         req_ready_q   <= 1'b1;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         cur_gen_q     <= 3'd1;
         fei_q         <= 1'b0;
         Rate          <= '0;
         PCLKRate      <= '0;
         width         <= W1;
         PclkChangeAck <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ltssm.req_valid && req_ready_q) begin
                  if (ltssm.req_gen == 3'd0 || ltssm.req_gen > MAX_GEN_C) begin
                     error_q <= 1'b1;
                  end else if (ltssm.req_gen == cur_gen_q) begin
                     done_q <= 1'b1;
                  end else begin
                     target_gen  <= ltssm.req_gen;
                     lane_mask   <= ltssm.active_lanes;
                     settle_cnt  <= '0;
                     fei_q       <= 1'b1;
                     req_ready_q <= 1'b0;
                     state       <= ST_ELEC_IDLE;
                  end
               end
            end
            ST_ELEC_IDLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  Rate     <= gen_to_rate(target_gen);
                  PCLKRate <= gen_to_pclkrate(target_gen);
                  width    <= gen_to_width(target_gen);
                  wd_cnt   <= '0;
                  state    <= ST_SET_RATE;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            ST_SET_RATE, ST_ACK: begin
               // Watchdog spans both states; completion is checked before expiry.
               if (state == ST_SET_RATE && PclkChangeOk) begin
                  PclkChangeAck <= 1'b1;
                  wd_cnt        <= wd_cnt + 1'b1;
                  state         <= ST_ACK;
               end else if (state == ST_ACK && all_done) begin
                  done_q        <= 1'b1;
                  PclkChangeAck <= 1'b0;
                  fei_q         <= 1'b0;
                  cur_gen_q     <= target_gen;
                  state         <= ST_DONE;
               end else if (wd_cnt == WD_LIMIT) begin
                  error_q       <= 1'b1;
                  PclkChangeAck <= 1'b0;
                  fei_q         <= 1'b0;
                  Rate          <= gen_to_rate(cur_gen_q);
                  PCLKRate      <= gen_to_pclkrate(cur_gen_q);
                  width         <= gen_to_width(cur_gen_q);
                  state         <= ST_ERROR;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            ST_DONE, ST_ERROR: begin
               req_ready_q <= 1'b1;
               state       <= ST_IDLE;
            end
            default: begin
               req_ready_q <= 1'b1;
               state       <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pipe_rate_change_ctrl.sv
// Scoreboard bench for pipe_rate_change_ctrl: MAX_GEN=3, SETTLE_CYCLES=4, TIMEOUT_CYCLES=16.
module tb_pipe_rate_change_ctrl;
   localparam int unsigned L = 16;

   typedef struct {
      bit         is_err;
      logic [2:0] gen;
      logic [3:0] rate;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   rate;
   logic [4:0]   pclkrate;
   logic [1:0]   width;
   logic         pclk_ok;
   logic         pclk_ack;
   logic [L-1:0] phy;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   pipe_rate_change_ctrl_if #(.LANESNUMBER(L)) ltssm ();

   pipe_rate_change_ctrl #(
      .LANESNUMBER   (L),
      .GEN1_PIPEWIDTH(8),
      .GEN2_PIPEWIDTH(16),
      .GEN3_PIPEWIDTH(8),
      .GEN4_PIPEWIDTH(32),
      .GEN5_PIPEWIDTH(8),
      .MAX_GEN       (3),
      .SETTLE_CYCLES (4),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .CLK          (clk),
      .lpreset      (rst_n),
      .ltssm        (ltssm),
      .Rate         (rate),
      .PCLKRate     (pclkrate),
      .width        (width),
      .PclkChangeOk (pclk_ok),
      .PclkChangeAck(pclk_ack),
      .PhyStatus    (phy)
   );

   always #5 clk = ~clk;

   // Leaves the bench at the negedge of cycle N+1 (N = accept cycle).
   task automatic request(input logic [2:0] gen, input logic [L-1:0] lanes);
      int unsigned n = 0;
      @(negedge clk);
      while (!ltssm.req_ready && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (ltssm.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL req_ready_wait: got %b, required 1", ltssm.req_ready);
      end
      ltssm.req_valid = 1'b1;
      ltssm.req_gen = gen;
      ltssm.active_lanes = lanes;
      @(negedge clk);
      ltssm.req_valid = 1'b0;
   endtask

   task automatic wait_resp(input string name);
      exp_t e;
      int unsigned n = 0;
      while (!(ltssm.done || ltssm.error) && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (!(ltssm.done || ltssm.error)) begin
         errors++;
         $display("FAIL %s_resp: got no done/error, required a response", name);
         if (sb.size() != 0) void'(sb.pop_front());
         return;
      end
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s_sb: got done=%b error=%b, required no response", name, ltssm.done, ltssm.error);
         return;
      end
      e = sb.pop_front();
      if ({ltssm.error, ltssm.done} !== {e.is_err, !e.is_err}) begin
         errors++;
         $display("FAIL %s_kind: got error=%b done=%b, required error=%b", name, ltssm.error, ltssm.done, e.is_err);
      end
      checks++;
      if (ltssm.cur_gen !== e.gen) begin
         errors++;
         $display("FAIL %s_cur_gen: got %0d, required %0d", name, ltssm.cur_gen, e.gen);
      end
      checks++;
      if (rate !== e.rate) begin
         errors++;
         $display("FAIL %s_rate: got %0d, required %0d", name, rate, e.rate);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({ltssm.cur_gen, rate, pclkrate, width} !== {3'd1, 4'd0, 5'd0, 2'd0}) begin
         errors++;
         $display("FAIL reset_pipe: got gen=%0d rate=%0d pclk=%0d width=%0d, required 1/0/0/0",
                  ltssm.cur_gen, rate, pclkrate, width);
      end
      checks++;
      if ({ltssm.req_ready, ltssm.done, ltssm.error, ltssm.force_elec_idle, pclk_ack} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b, required 10000",
                  {ltssm.req_ready, ltssm.done, ltssm.error, ltssm.force_elec_idle, pclk_ack});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_gen_change();
      pclk_ok = 1'b1;
      phy = '0;
      sb.push_back('{is_err: 1'b0, gen: 3'd2, rate: 4'd1});
      request(3'd2, 16'h000F);
      checks++;
      if (ltssm.force_elec_idle !== 1'b1 || ltssm.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL gc_fei: got fei=%b ready=%b, required 1/0", ltssm.force_elec_idle, ltssm.req_ready);
      end
      phy = '1;
      repeat (3) @(negedge clk);
      checks++;
      if (rate !== 4'd0) begin
         errors++;
         $display("FAIL gc_rate_early: got %0d, required 0", rate);
      end
      @(negedge clk);
      phy = '0;
      checks++;
      if ({rate, pclkrate, width, pclk_ack} !== {4'd1, 5'd1, 2'd1, 1'b0}) begin
         errors++;
         $display("FAIL gc_set_rate: got rate=%0d pclk=%0d width=%0d ack=%b, required 1/1/1/0",
                  rate, pclkrate, width, pclk_ack);
      end
      @(negedge clk);
      checks++;
      if (pclk_ack !== 1'b1) begin
         errors++;
         $display("FAIL gc_ack: got %b, required 1", pclk_ack);
      end
      for (int i = 0; i < 4; i++) begin
         phy = (16'h0001 << i) | 16'h0100;
         @(negedge clk);
         phy = '0;
         if (i < 3) begin
            checks++;
            if (ltssm.done !== 1'b0 || pclk_ack !== 1'b1) begin
               errors++;
               $display("FAIL gc_early_done_%0d: got done=%b ack=%b, required 0/1", i, ltssm.done, pclk_ack);
            end
         end
      end
      wait_resp("gen_change");
      checks++;
      if (pclk_ack !== 1'b0 || ltssm.force_elec_idle !== 1'b0) begin
         errors++;
         $display("FAIL gc_release: got ack=%b fei=%b, required 0/0", pclk_ack, ltssm.force_elec_idle);
      end
      @(negedge clk);
      checks++;
      if (ltssm.req_ready !== 1'b1 || ltssm.done !== 1'b0) begin
         errors++;
         $display("FAIL gc_ready: got ready=%b done=%b, required 1/0", ltssm.req_ready, ltssm.done);
      end
   endtask

   task automatic test_same_gen();
      sb.push_back('{is_err: 1'b0, gen: 3'd2, rate: 4'd1});
      request(3'd2, 16'h000F);
      checks++;
      if (ltssm.done !== 1'b1) begin
         errors++;
         $display("FAIL same_latency: got done=%b, required 1", ltssm.done);
      end
      wait_resp("same_gen");
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (ltssm.force_elec_idle !== 1'b0 || ltssm.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL same_idle_%0d: got fei=%b ready=%b, required 0/1", i, ltssm.force_elec_idle, ltssm.req_ready);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_invalid();
      logic [2:0] bad[2];
      bad[0] = 3'd4;
      bad[1] = 3'd0;
      for (int i = 0; i < 2; i++) begin
         sb.push_back('{is_err: 1'b1, gen: 3'd2, rate: 4'd1});
         request(bad[i], 16'h000F);
         checks++;
         if (ltssm.error !== 1'b1 || ltssm.req_ready !== 1'b1 || ltssm.force_elec_idle !== 1'b0) begin
            errors++;
            $display("FAIL invalid_%0d: got err=%b ready=%b fei=%b, required 1/1/0",
                     bad[i], ltssm.error, ltssm.req_ready, ltssm.force_elec_idle);
         end
         wait_resp("invalid");
      end
   endtask

   task automatic test_timeout();
      int unsigned n = 0;
      int unsigned k = 0;
      pclk_ok = 1'b0;
      sb.push_back('{is_err: 1'b1, gen: 3'd2, rate: 4'd1});
      request(3'd3, 16'h000F);
      while (rate !== 4'd2 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (rate !== 4'd2 || width !== 2'd0 || n != 4) begin
         errors++;
         $display("FAIL to_set_rate: got rate=%0d width=%0d after %0d, required 2/0 after 4", rate, width, n);
      end
      while (ltssm.error !== 1'b1 && k < 60) begin @(negedge clk); k++; end
      checks++;
      if (k != 17) begin
         errors++;
         $display("FAIL to_latency: got %0d cycles, required 17", k);
      end
      wait_resp("timeout");
      checks++;
      if ({pclkrate, width, ltssm.force_elec_idle, pclk_ack} !== {5'd1, 2'd1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL to_revert: got pclk=%0d width=%0d fei=%b ack=%b, required 1/1/0/0",
                  pclkrate, width, ltssm.force_elec_idle, pclk_ack);
      end
      pclk_ok = 1'b1;
   endtask

   task automatic test_reset_mid();
      int unsigned n = 0;
      phy = '0;
      request(3'd3, 16'h000F);
      while (pclk_ack !== 1'b1 && n < 30) begin @(negedge clk); n++; end
      checks++;
      if (pclk_ack !== 1'b1) begin
         errors++;
         $display("FAIL rm_reach_ack: got %b, required 1", pclk_ack);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({pclk_ack, ltssm.cur_gen, rate, width, ltssm.force_elec_idle, ltssm.req_ready} !==
          {1'b0, 3'd1, 4'd0, 2'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL rm_async: got ack=%b gen=%0d rate=%0d width=%0d fei=%b ready=%b, required 0/1/0/0/0/1",
                  pclk_ack, ltssm.cur_gen, rate, width, ltssm.force_elec_idle, ltssm.req_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      phy = '1;
      sb.push_back('{is_err: 1'b0, gen: 3'd2, rate: 4'd1});
      request(3'd2, 16'h000F);
      repeat (6) @(negedge clk);
      checks++;
      if (ltssm.done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_latency: got done=%b at N+7, required 1", ltssm.done);
      end
      wait_resp("b2b_first");
      @(negedge clk);
      checks++;
      if (ltssm.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready: got %b at N+8, required 1", ltssm.req_ready);
      end
      phy = '0;
      sb.push_back('{is_err: 1'b0, gen: 3'd3, rate: 4'd2});
      request(3'd3, '0);
      wait_resp("b2b_no_lanes");
   endtask

   initial begin
      ltssm.req_valid = 1'b0;
      ltssm.req_gen = 3'd1;
      ltssm.active_lanes = '0;
      pclk_ok = 1'b0;
      phy = '0;
      test_reset();
      test_gen_change();
      test_same_gen();
      test_invalid();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1);
   end
endmodule

// File: doc/pipe_rate_change_ctrl.md
# pipe_rate_change_ctrl

Sequences PIPE rate changes for the PCIe physical layer. It takes a target-generation request from the LTSSM and drives the MAC side of the PIPE rate/PCLK handshake on all lanes. It holds the transmitter in electrical idle during the change and reports completion or timeout back to the LTSSM. It sits between mainLTSSM and the PIPE command signals (Rate, PCLKRate, PclkChangeAck, width) at the PCIe top level.

## Interface
Parameters:
- LANESNUMBER, 16, number of PIPE lanes
- GEN1_PIPEWIDTH … GEN5_PIPEWIDTH, 8, PIPE data width in bits per generation (8/16/32)
- MAX_GEN, 1, highest supported generation (1..5)
- SETTLE_CYCLES, 4, cycles of forced electrical idle before the rate is driven (≥1)
- TIMEOUT_CYCLES, 1024, handshake watchdog limit

Ports:
- CLK  in  1  PIPE clock
- lpreset  in  1  asynchronous, active-low reset
- req_valid  in  1  rate-change request
- req_gen  in  3  target generation (1..5)
- req_ready  out  1  controller idle, request accepted when valid&ready
- active_lanes  in  LANESNUMBER  lane mask, sampled at accept
- done  out  1  one-cycle pulse, change complete
- error  out  1  one-cycle pulse, invalid request or timeout
- cur_gen  out  3  generation currently in effect
- force_elec_idle  out  1  TX must drive TxElecIdle on all lanes
- Rate  out  4  PIPE Rate
- PCLKRate  out  5  PIPE PCLKRate
- width  out  2  PIPE width code
- PclkChangeOk  in  1  PHY ready for PCLK change
- PclkChangeAck  out  1  MAC PCLK change complete
- PhyStatus  in  LANESNUMBER  per-lane PHY status

## Operation
- Encodings:
  - Rate = gen−1.
  - PCLKRate = {2'b0, gen−1}.
  - width = 0/1/2 for GENx_PIPEWIDTH = 8/16/32.
- Reset values:
  - cur_gen=1, Rate=0, PCLKRate=0, width=code(GEN1_PIPEWIDTH).
  - req_ready=1, done=0, error=0, force_elec_idle=0, PclkChangeAck=0, state IDLE.
- Request handling on accept:
  - req_gen==0 or req_gen>MAX_GEN: error pulses the next cycle and the state stays IDLE.
  - req_gen==cur_gen: done pulses the next cycle with no PIPE handshake.
  - Otherwise the target and active_lanes are latched and the FSM goes to ELEC_IDLE.
- FSM states and transitions:
  - IDLE: req_ready=1.
  - ELEC_IDLE: force_elec_idle=1; a counter runs SETTLE_CYCLES cycles, then → SET_RATE.
  - SET_RATE: Rate, PCLKRate and width take the target encodings on entry. Wait for PclkChangeOk=1, then → ACK. The watchdog starts on entry.
  - ACK: PclkChangeAck=1. A sticky collector ORs PhyStatus&active_lanes each cycle. When (seen | ~active_lanes) is all ones → DONE. An all-zero active_lanes completes on the first ACK cycle.
  - DONE: one cycle. done=1, PclkChangeAck=0, force_elec_idle=0, cur_gen=target, collector cleared → IDLE.
  - ERROR: entered when the watchdog reaches TIMEOUT_CYCLES in SET_RATE or ACK. One cycle: error=1, PclkChangeAck=0, force_elec_idle=0, Rate/PCLKRate/width revert to cur_gen, cur_gen unchanged → IDLE.
- Signals ignored outside their states:
  - PhyStatus outside ACK.
  - PclkChangeOk outside SET_RATE.
- req_valid while not ready: ignored, no queuing.
- Reset mid-operation: every output returns asynchronously to its reset value, including cur_gen=1.

## Timing
- All outputs are registered.
- Request accepted in cycle N, with PclkChangeOk and PhyStatus already high:
  - force_elec_idle rises in N+1.
  - Rate changes in N+SETTLE_CYCLES+1.
  - PclkChangeAck is high in N+SETTLE_CYCLES+2.
  - done is high in N+SETTLE_CYCLES+3.
  - req_ready returns in N+SETTLE_CYCLES+4.
- Invalid or same-gen requests: error or done in N+1, req_ready stays high.
- Timeout: error is high TIMEOUT_CYCLES+1 cycles after SET_RATE entry.
- A simultaneous last-lane PhyStatus and watchdog expiry resolves to DONE (completion wins).

## Structure
- Package pipe_rate_pkg holds:
  - the state enum;
  - functions gen_to_rate, gen_to_pclkrate and pipewidth_to_code;
  - width code constants.
- Sub-module phystatus_collector(LANESNUMBER) provides the sticky per-lane OR, clear and all-done flag.

## Test plan
- Reset, then read outputs → cur_gen=1, Rate=0, width=0, req_ready=1, all other outputs 0.
- MAX_GEN=3, req_gen=2, active_lanes=16'h000F, PclkChangeOk held high, PhyStatus pulsed on lanes 0-3 in different ACK cycles:
  - Rate=1 and PCLKRate=1.
  - done appears only after the fourth lane reports.
  - cur_gen=2.
- req_gen=2 while cur_gen=2 → done in N+1, Rate unchanged, force_elec_idle never asserted.
- req_gen=4 with MAX_GEN=3 → error in N+1, no state change.
- PclkChangeOk never asserted, TIMEOUT_CYCLES=16:
  - error 17 cycles after Rate changes.
  - Rate reverts to the previous value, cur_gen unchanged.
- lpreset dropped while in ACK → PclkChangeAck=0 and cur_gen=1 immediately; a new request afterwards completes normally.
